// File: rtl/mfp_ahb_rojo_mc_if.sv
// AHB-lite signal bundle between the MIPSfpga bus and the multi-bot Rojobot peripheral.
// The master drives address/control/write data; the slave returns registered read data.
interface mfp_ahb_rojo_mc_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (output HADDR, HTRANS, HWDATA, HWRITE, HSEL, input HRDATA);
    modport slave  (input HADDR, HTRANS, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_rojo_mc.sv
// AHB-lite slave for up to eight Rojobot channels: per-bot control, live info, update
// snapshots, and sticky maskable update interrupts with overrun tracking and acknowledge.
module mfp_ahb_rojo_mc #(
    parameter int          NUM_BOTS    = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1F800100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    mfp_ahb_rojo_mc_if.slave        ahb,
    output logic [8*NUM_BOTS-1:0]   IO_BotCtrl,
    input  logic [32*NUM_BOTS-1:0]  IO_BotInfo,
    input  logic [NUM_BOTS-1:0]     IO_BotUpdt,
    output logic [NUM_BOTS-1:0]     IO_INT_ACK,
    output logic                    IRQ
);
    localparam logic [4:0] OFF_PEND = 5'h18;
    localparam logic [4:0] OFF_MASK = 5'h19;
    localparam logic [4:0] OFF_OVR  = 5'h1A;

    logic [7:0]          r_ctrl [NUM_BOTS];
    logic [31:0]         r_snap [NUM_BOTS];
    logic [NUM_BOTS-1:0] r_pending, r_mask, r_overrun, r_ack;
    logic [NUM_BOTS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_BOTS-1:0] r_sync_q;
    logic                r_irq;
    logic [31:0]         r_hrdata;
    logic                r_wr_en;
    logic [4:0]          r_wr_off;

    logic                w_hit, w_act, w_re, w_rd_fwd;
    logic [NUM_BOTS-1:0] w_upd, w_pend_clr, w_ovr_clr, w_pend_nxt, w_ovr_nxt, w_mask_nxt;
    logic [7:0]          w_ctrl_nxt [NUM_BOTS];
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_hit    = (ahb.HADDR[31:7] == BASE_ADDR[31:7]);
    assign w_act    = ahb.HSEL && (ahb.HTRANS != 2'b00);
    assign w_re     = w_act && !ahb.HWRITE;
    assign w_rd_fwd = r_wr_en && (r_wr_off == ahb.HADDR[6:2]);
    assign w_unused = ^{ahb.HADDR[1:0], ahb.HWDATA[31:8]};

    assign w_upd      = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_pend_clr = (r_wr_en && r_wr_off == OFF_PEND) ? ahb.HWDATA[NUM_BOTS-1:0] : '0;
    assign w_ovr_clr  = (r_wr_en && r_wr_off == OFF_OVR)  ? ahb.HWDATA[NUM_BOTS-1:0] : '0;
    assign w_mask_nxt = (r_wr_en && r_wr_off == OFF_MASK) ? ahb.HWDATA[NUM_BOTS-1:0] : r_mask;
    // A new event on a bot that is being acknowledged in the same cycle is not an overrun.
    assign w_pend_nxt = (r_pending & ~w_pend_clr) | w_upd;
    assign w_ovr_nxt  = (r_overrun & ~w_ovr_clr) | (w_upd & r_pending & ~w_pend_clr);

    always_comb begin
        for (int i = 0; i < NUM_BOTS; i++) begin
            w_ctrl_nxt[i] = r_ctrl[i];
            if (r_wr_en && r_wr_off == 5'(i))
                w_ctrl_nxt[i] = ahb.HWDATA[7:0];
        end
    end

    // Read mux uses next-state values where a write to the same register is committing.
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (ahb.HADDR[6:5])
                2'b00: for (int i = 0; i < NUM_BOTS; i++)
                           if (ahb.HADDR[4:2] == 3'(i)) w_rdata = {24'h0, w_ctrl_nxt[i]};
                2'b01: for (int i = 0; i < NUM_BOTS; i++)
                           if (ahb.HADDR[4:2] == 3'(i)) w_rdata = IO_BotInfo[32*i +: 32];
                2'b10: for (int i = 0; i < NUM_BOTS; i++)
                           if (ahb.HADDR[4:2] == 3'(i)) w_rdata = r_snap[i];
                default: begin
                    case (ahb.HADDR[4:2])
                        3'd0:    w_rdata = 32'(w_rd_fwd ? w_pend_nxt : r_pending);
                        3'd1:    w_rdata = 32'(w_mask_nxt);
                        3'd2:    w_rdata = 32'(w_rd_fwd ? w_ovr_nxt : r_overrun);
                        3'd3:    w_rdata = {16'hB07C, 12'h0, 4'(NUM_BOTS)};
                        default: w_rdata = '0;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_en   <= 1'b0;
            r_wr_off  <= '0;
            r_hrdata  <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_overrun <= '0;
            r_ack     <= '0;
            r_irq     <= 1'b0;
            r_sync_q  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            for (int i = 0; i < NUM_BOTS; i++) begin
                r_ctrl[i] <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_wr_en  <= w_act && ahb.HWRITE && w_hit;
            r_wr_off <= ahb.HADDR[6:2];
            if (w_re) r_hrdata <= w_rdata;
            r_sync[0] <= IO_BotUpdt;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_sync_q  <= r_sync[SYNC_STAGES-1];
            r_pending <= w_pend_nxt;
            r_mask    <= w_mask_nxt;
            r_overrun <= w_ovr_nxt;
            r_ack     <= w_pend_clr;
            r_irq     <= |(r_pending & r_mask);
            for (int i = 0; i < NUM_BOTS; i++) begin
                r_ctrl[i] <= w_ctrl_nxt[i];
                if (w_upd[i]) r_snap[i] <= IO_BotInfo[32*i +: 32];
            end
        end
    end

    for (genvar g = 0; g < NUM_BOTS; g++) begin : g_ctrl
        assign IO_BotCtrl[8*g +: 8] = r_ctrl[g];
    end

    assign ahb.HRDATA = r_hrdata;
    assign IO_INT_ACK = r_ack;
    assign IRQ        = r_irq;
endmodule

// File: tb/tb_mfp_ahb_rojo_mc.sv
// Bench for mfp_ahb_rojo_mc: directed scenarios plus a randomized mix of bus and bot
// activity, checked against a register-map level model of the peripheral.
module tb_mfp_ahb_rojo_mc;
    localparam int          NB   = 2;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h1F800100;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic [8*NB-1:0]     bot_ctrl;
    logic [32*NB-1:0]    bot_info;
    logic [NB-1:0]       bot_updt;
    logic [NB-1:0]       int_ack;
    logic                irq;

    mfp_ahb_rojo_mc_if bus ();

    mfp_ahb_rojo_mc #(.NUM_BOTS(NB), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
        .IO_BotCtrl(bot_ctrl), .IO_BotInfo(bot_info), .IO_BotUpdt(bot_updt),
        .IO_INT_ACK(int_ack), .IRQ(irq)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the programmer-visible state
    logic [7:0]  m_ctrl [NB];
    logic [31:0] m_snap [NB];
    logic [NB-1:0] m_pend, m_mask, m_ovr;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin m_ctrl[i] = '0; m_snap[i] = '0; end
        m_pend = '0; m_mask = '0; m_ovr = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [6:0] off);
        int idx;
        idx = int'(off[4:2]);
        case (off[6:5])
            2'b00: if (idx < NB) return {24'h0, m_ctrl[idx]};
            2'b01: if (idx < NB) return bot_info[32*idx +: 32];
            2'b10: if (idx < NB) return m_snap[idx];
            default: begin
                if (idx == 0) return 32'(m_pend);
                if (idx == 1) return 32'(m_mask);
                if (idx == 2) return 32'(m_ovr);
                if (idx == 3) return {16'hB07C, 12'h0, 4'(NB)};
            end
        endcase
        return 32'h0;
    endfunction

    task automatic bus_idle();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    endtask

    task automatic addr_phase(input logic [6:0] off, input logic wr);
        bus.HADDR = BASE | {25'h0, off}; bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write_raw(input logic [31:0] addr, input logic sel, input logic [1:0] trans,
                                 input logic [31:0] d);
        bus.HADDR = addr; bus.HSEL = sel; bus.HTRANS = trans; bus.HWRITE = 1'b1;
        @(posedge HCLK); #1;
        bus_idle(); bus.HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_write(input logic [6:0] off, input logic [31:0] d);
        bus_write_raw(BASE | {25'h0, off}, 1'b1, 2'b10, d);
    endtask

    task automatic ahb_read(input logic [6:0] off, output logic [31:0] d);
        addr_phase(off, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        d = bus.HRDATA;
    endtask

    task automatic ahb_write_read(input logic [6:0] off, input logic [31:0] d, output logic [31:0] rd);
        addr_phase(off, 1'b1);
        @(posedge HCLK); #1;
        bus.HWDATA = d;
        addr_phase(off, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        rd = bus.HRDATA;
    endtask

    task automatic pulse(input logic [NB-1:0] bits, input logic [32*NB-1:0] info_after);
        bot_updt = bot_updt | bits;
        repeat (SS + 1) @(posedge HCLK);
        #1;
        for (int i = 0; i < NB; i++) begin
            if (bits[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_snap[i] = bot_info[32*i +: 32];
            end
        end
        bot_info = info_after;
        bot_updt = bot_updt & ~bits;
        repeat (SS + 1) @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        HRESETn = 1'b1; bus_idle(); bus.HADDR = '0; bus.HWDATA = '0;
        bot_info = '0; bot_updt = '0;
        #3 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        n_tests++; if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
        n_tests++; if (bot_ctrl !== '0) begin n_fail++; $display("FAIL reset_botctrl: got %h want 0", bot_ctrl); end
        n_tests++; if (int_ack !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_ack_irq: got %b/%b want 0/0", int_ack, irq); end
        HRESETn = 1'b1;
        model_reset();
        @(posedge HCLK); #1;
        for (int k = 0; k < 28; k++) begin
            logic [6:0] off;
            off = 7'(k << 2);
            ahb_read(off, rd);
            n_tests++; if (rd !== m_read(off)) begin n_fail++; $display("FAIL reset_read_%h: got %h want %h", off, rd, m_read(off)); end
        end
    endtask

    task automatic test_ctrl_roundtrip();
        logic [31:0] rd;
        addr_phase(7'h04, 1'b1);
        @(posedge HCLK); #1;
        n_tests++; if (bot_ctrl[15:8] !== 8'h00) begin n_fail++; $display("FAIL ctrl_early: got %h want 00", bot_ctrl[15:8]); end
        bus.HWDATA = 32'hFFFF_FFA5;
        addr_phase(7'h04, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        rd = bus.HRDATA;
        m_ctrl[1] = 8'hA5;
        n_tests++; if (bot_ctrl[15:8] !== 8'hA5) begin n_fail++; $display("FAIL ctrl_out: got %h want a5", bot_ctrl[15:8]); end
        n_tests++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL ctrl_fwd: got %h want 000000a5", rd); end
        n_tests++; if (bot_ctrl[7:0] !== 8'h00) begin n_fail++; $display("FAIL ctrl_other: got %h want 00", bot_ctrl[7:0]); end
    endtask

    task automatic test_update_snapshot();
        logic [31:0] rd;
        bot_info[31:0] = 32'h1234_5678;
        pulse(2'b01, '0);
        ahb_read(7'h60, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL upd_pending: got %h want 1", rd); end
        ahb_read(7'h40, rd);
        n_tests++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL upd_snap: got %h want 12345678", rd); end
        ahb_read(7'h20, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL upd_live: got %h want 0", rd); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL upd_irq_masked: got %b want 0", irq); end
        ahb_write(7'h64, 32'h1); m_mask = 2'b01;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_early: got %b want 0", irq); end
        @(posedge HCLK); #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq: got %b want 1", irq); end
    endtask

    task automatic test_latency();
        ahb_write(7'h64, 32'h2); m_mask = 2'b10;
        @(posedge HCLK); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_irq_pre: got %b want 0", irq); end
        bot_info[63:32] = $urandom;
        bot_updt[1] = 1'b1;
        repeat (SS + 1) @(posedge HCLK);
        #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_irq_early: got %b want 0", irq); end
        @(posedge HCLK); #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL lat_irq: got %b want 1", irq); end
        m_pend[1] = 1'b1; m_snap[1] = bot_info[63:32];
        bot_updt[1] = 1'b0;
        repeat (SS + 1) @(posedge HCLK);
        #1;
    endtask

    task automatic test_ack();
        logic [31:0] rd;
        ahb_write(7'h64, 32'h3); m_mask = 2'b11;
        @(posedge HCLK); #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ack_irq_pre: got %b want 1", irq); end
        ahb_write_read(7'h60, 32'h2, rd);
        m_pend = 2'b01;
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ack_fwd: got %h want 1", rd); end
        n_tests++; if (int_ack !== 2'b10) begin n_fail++; $display("FAIL ack_pulse: got %b want 10", int_ack); end
        @(posedge HCLK); #1;
        n_tests++; if (int_ack !== 2'b00) begin n_fail++; $display("FAIL ack_width: got %b want 00", int_ack); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ack_irq: got %b want 1", irq); end
    endtask

    task automatic test_overrun_collision();
        logic [31:0] rd;
        logic [31:0] v;
        bot_info[31:0] = $urandom;
        pulse(2'b01, {$urandom, $urandom});
        ahb_read(7'h68, rd);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ovr_set: got %h want 1", rd); end
        v = $urandom;
        bot_info[31:0] = v;
        bot_updt[0] = 1'b1;
        repeat (SS - 1) @(posedge HCLK);
        #1;
        addr_phase(7'h60, 1'b1);
        @(posedge HCLK); #1;
        bus_idle(); bus.HWDATA = 32'h1;
        @(posedge HCLK); #1;
        m_snap[0] = v;
        n_tests++; if (int_ack !== 2'b01) begin n_fail++; $display("FAIL coll_ack: got %b want 01", int_ack); end
        @(posedge HCLK); #1;
        n_tests++; if (int_ack !== 2'b00) begin n_fail++; $display("FAIL coll_ack_width: got %b want 00", int_ack); end
        bot_updt[0] = 1'b0;
        repeat (SS + 1) @(posedge HCLK);
        #1;
        ahb_read(7'h60, rd);
        n_tests++; if (rd !== 32'(m_pend)) begin n_fail++; $display("FAIL coll_pending: got %h want %h", rd, m_pend); end
        ahb_read(7'h68, rd);
        n_tests++; if (rd !== 32'(m_ovr)) begin n_fail++; $display("FAIL coll_overrun: got %h want %h", rd, m_ovr); end
        ahb_read(7'h40, rd);
        n_tests++; if (rd !== v) begin n_fail++; $display("FAIL coll_snap: got %h want %h", rd, v); end
        ahb_write(7'h68, 32'h1); m_ovr[0] = 1'b0;
        ahb_read(7'h68, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ovr_clear: got %h want 0", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        ahb_read(7'h08, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL dec_08: got %h want 0", rd); end
        ahb_read(7'h70, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL dec_70: got %h want 0", rd); end
        ahb_read(7'h6C, rd);
        n_tests++; if (rd !== 32'hB07C_0002) begin n_fail++; $display("FAIL dec_id: got %h want b07c0002", rd); end
        bot_info[31:0] = $urandom;
        ahb_write(7'h20, ~bot_info[31:0]);
        ahb_read(7'h20, rd);
        n_tests++; if (rd !== bot_info[31:0]) begin n_fail++; $display("FAIL dec_ro: got %h want %h", rd, bot_info[31:0]); end
        bus_write_raw(BASE, 1'b1, 2'b00, 32'h77);
        bus_write_raw(BASE, 1'b0, 2'b10, 32'h66);
        bus_write_raw(BASE + 32'h80, 1'b1, 2'b10, 32'h55);
        ahb_read(7'h00, rd);
        n_tests++; if (rd !== {24'h0, m_ctrl[0]}) begin n_fail++; $display("FAIL dec_ignored: got %h want %h", rd, m_ctrl[0]); end
    endtask

    task automatic test_random();
        logic [31:0]   d, rd;
        logic [6:0]    off;
        logic [NB-1:0] bits;
        int            bot;
        for (int it = 0; it < 60; it++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    bot = $urandom_range(0, NB - 1);
                    ahb_write(7'(bot << 2), d);
                    m_ctrl[bot] = d[7:0];
                    n_tests++; if (bot_ctrl[8*bot +: 8] !== m_ctrl[bot]) begin n_fail++; $display("FAIL rnd_ctrl%0d: got %h want %h", bot, bot_ctrl[8*bot +: 8], m_ctrl[bot]); end
                end
                1: begin ahb_write(7'h64, d); m_mask = d[NB-1:0]; end
                2: begin
                    bits = NB'($urandom);
                    bot_info = {$urandom, $urandom};
                    pulse(bits, {$urandom, $urandom});
                end
                3: begin
                    ahb_write(7'h60, d);
                    m_pend = m_pend & ~d[NB-1:0];
                    n_tests++; if (int_ack !== d[NB-1:0]) begin n_fail++; $display("FAIL rnd_ack: got %b want %b", int_ack, d[NB-1:0]); end
                end
                default: begin ahb_write(7'h68, d); m_ovr = m_ovr & ~d[NB-1:0]; end
            endcase
            @(posedge HCLK); #1;
            n_tests++; if (irq !== |(m_pend & m_mask)) begin n_fail++; $display("FAIL rnd_irq: got %b want %b", irq, |(m_pend & m_mask)); end
            n_tests++; if (int_ack !== '0) begin n_fail++; $display("FAIL rnd_ack_idle: got %b want 0", int_ack); end
            off = 7'($urandom_range(0, 31) << 2);
            ahb_read(off, rd);
            n_tests++; if (rd !== m_read(off)) begin n_fail++; $display("FAIL rnd_read_%h: got %h want %h", off, rd, m_read(off)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        ahb_write(7'h00, 32'h33); m_ctrl[0] = 8'h33;
        ahb_write(7'h64, 32'h3);  m_mask = 2'b11;
        bot_info = {$urandom, $urandom};
        pulse(2'b11, {$urandom, $urandom});
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rmid_irq_pre: got %b want 1", irq); end
        ahb_read(7'h6C, rd);
        addr_phase(7'h00, 1'b1);
        @(posedge HCLK); #1;
        bus_idle(); bus.HWDATA = 32'h5A;
        #2 HRESETn = 1'b0;
        #1;
        n_tests++; if (bus.HRDATA !== 32'h0 || bot_ctrl !== '0) begin n_fail++; $display("FAIL rmid_outs: got %h/%h want 0/0", bus.HRDATA, bot_ctrl); end
        n_tests++; if (irq !== 1'b0 || int_ack !== '0) begin n_fail++; $display("FAIL rmid_irq: got %b/%b want 0/0", irq, int_ack); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        model_reset();
        @(posedge HCLK); #1;
        ahb_read(7'h00, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rmid_ctrl: got %h want 0", rd); end
        ahb_read(7'h60, rd);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rmid_pending: got %h want 0", rd); end
        ahb_write(7'h04, 32'h3C); m_ctrl[1] = 8'h3C;
        n_tests++; if (bot_ctrl !== {m_ctrl[1], m_ctrl[0]}) begin n_fail++; $display("FAIL rmid_after: got %h want %h", bot_ctrl, {m_ctrl[1], m_ctrl[0]}); end
    endtask

    initial begin
        test_reset();
        test_ctrl_roundtrip();
        test_update_snapshot();
        test_latency();
        test_ack();
        test_overrun_collision();
        test_decode();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end
endmodule
